// File: rtl/draw_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// draw_cmd_arbiter
//
// Schedules rectangle draw commands from two requesters (host port and
// display-list reader) onto the single shared rasteriser engine. Requesters
// are granted round-robin. Each accepted rectangle is normalised so that
// x0<=x1 and y0<=y1. The engine then gets a one-cycle start pulse, and the
// operands are held stable until the engine reports done. Pixels emitted by
// the engine are counted per command. A watchdog aborts an engine that never
// finishes.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   req_valid[1:0]     per-requester command valid
//   req_ready[1:0]     per-requester accept (combinational, IDLE only)
//   req_cmd[113:0]     two packed 57-bit commands, req i at [57i+56:57i],
//                      fields MSB->LSB: x0, y0, x1, y1, fill, color[23:0]
//   eng_start          one-cycle start pulse to the engine
//   eng_x0..eng_y1     normalised rectangle corners
//   eng_fill           fill_enable to the engine
//   eng_color          colour to the engine
//   eng_abort          one-cycle pulse, OR'd into the engine reset
//   eng_pixel_valid    engine pixel strobe
//   eng_done           engine completion pulse
//   busy               high in every state except IDLE
//   grant_id           requester owning the current/last command
//   pix_count          pixel count of the last completed or aborted command
//   cmd_done           one-cycle completion pulse
//   cmd_timeout        one-cycle abort pulse
// -----------------------------------------------------------------------------
module draw_cmd_arbiter #(
   parameter int TIMEOUT_CYCLES = 70000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [1:0]   req_valid,
   output logic [1:0]   req_ready,
   input  logic [113:0] req_cmd,
   output logic         eng_start,
   output logic [7:0]   eng_x0,
   output logic [7:0]   eng_y0,
   output logic [7:0]   eng_x1,
   output logic [7:0]   eng_y1,
   output logic         eng_fill,
   output logic [23:0]  eng_color,
   output logic         eng_abort,
   input  logic         eng_pixel_valid,
   input  logic         eng_done,
   output logic         busy,
   output logic         grant_id,
   output logic [16:0]  pix_count,
   output logic         cmd_done,
   output logic         cmd_timeout
);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      COMPLETE,
      ABORT
   } state_t;

   // The timer counts WAIT cycles from 0, so the abort fires on its last value.
   localparam logic [16:0] TIMER_LAST = 17'(TIMEOUT_CYCLES - 1);

   state_t        state;
   logic          rr;
   logic [16:0]   run_count;
   logic [16:0]   timer;
   logic          grant;
   logic [56:0]   cmd_sel;
   logic [7:0]    cmd_x0;
   logic [7:0]    cmd_y0;
   logic [7:0]    cmd_x1;
   logic [7:0]    cmd_y1;

   // Grant selection: the round-robin pointer wins when its requester is
   // valid, otherwise the other requester gets the slot. Ready is offered only
   // in IDLE, and only to the granted requester, so at most one bit is set.
   always_comb begin
      grant     = req_valid[rr] ? rr : ~rr;
      req_ready = 2'b00;
      if (state == IDLE && req_valid != 2'b00) begin
         req_ready[grant] = 1'b1;
      end
      cmd_sel = grant ? req_cmd[113:57] : req_cmd[56:0];
      cmd_x0  = cmd_sel[56:49];
      cmd_y0  = cmd_sel[48:41];
      cmd_x1  = cmd_sel[40:33];
      cmd_y1  = cmd_sel[32:25];
   end

   // Main sequencer. Pulse outputs default low and are raised on the edge
   // that enters ISSUE, COMPLETE or ABORT, so each is high for exactly the one
   // cycle spent in that state. The running pixel counter keeps counting on
   // the cycle where done arrives; pix_count takes its final value while in
   // COMPLETE/ABORT.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         rr          <= 1'b0;
         run_count   <= '0;
         timer       <= '0;
         eng_start   <= 1'b0;
         eng_abort   <= 1'b0;
         eng_x0      <= '0;
         eng_y0      <= '0;
         eng_x1      <= '0;
         eng_y1      <= '0;
         eng_fill    <= 1'b0;
         eng_color   <= '0;
         busy        <= 1'b0;
         grant_id    <= 1'b0;
         pix_count   <= '0;
         cmd_done    <= 1'b0;
         cmd_timeout <= 1'b0;
      end else begin
         eng_start   <= 1'b0;
         eng_abort   <= 1'b0;
         cmd_done    <= 1'b0;
         cmd_timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid != 2'b00) begin
                  eng_x0    <= (cmd_x0 <= cmd_x1) ? cmd_x0 : cmd_x1;
                  eng_x1    <= (cmd_x0 <= cmd_x1) ? cmd_x1 : cmd_x0;
                  eng_y0    <= (cmd_y0 <= cmd_y1) ? cmd_y0 : cmd_y1;
                  eng_y1    <= (cmd_y0 <= cmd_y1) ? cmd_y1 : cmd_y0;
                  eng_fill  <= cmd_sel[24];
                  eng_color <= cmd_sel[23:0];
                  grant_id  <= grant;
                  rr        <= ~grant;
                  run_count <= '0;
                  timer     <= '0;
                  eng_start <= 1'b1;
                  busy      <= 1'b1;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               state <= WAIT;
            end
            WAIT: begin
               if (eng_pixel_valid) begin
                  run_count <= run_count + 17'd1;
               end
               timer <= timer + 17'd1;
               if (eng_done) begin
                  cmd_done <= 1'b1;
                  state    <= COMPLETE;
               end else if (timer == TIMER_LAST) begin
                  eng_abort   <= 1'b1;
                  cmd_timeout <= 1'b1;
                  state       <= ABORT;
               end
            end
            COMPLETE, ABORT: begin
               pix_count <= run_count;
               busy      <= 1'b0;
               state     <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_draw_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_draw_cmd_arbiter
//
// Self-checking bench for draw_cmd_arbiter. Two instances are used. The main
// instance has the default watchdog and drives an engine stub that strobes one
// pixel per non-stalled cycle and raises done together with the last pixel.
// The second instance has a 16-cycle watchdog and an engine that never
// finishes. Expected command results are pushed to a scoreboard queue when a
// command is handed over and popped when the DUT reports completion.
// -----------------------------------------------------------------------------
module tb_draw_cmd_arbiter;

   typedef struct {
      logic        g;
      logic [56:0] ops;
      int          count;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic [1:0]   req_valid, req_ready;
   logic [113:0] req_cmd;
   logic         eng_start, eng_abort, eng_fill, eng_pixel_valid, eng_done;
   logic [7:0]   eng_x0, eng_y0, eng_x1, eng_y1;
   logic [23:0]  eng_color;
   logic         busy, grant_id, cmd_done, cmd_timeout;
   logic [16:0]  pix_count;

   logic [1:0]   t_valid, t_ready;
   logic [113:0] t_cmd;
   logic         t_start, t_abort, t_fill, t_pv, t_done;
   logic [7:0]   t_x0, t_y0, t_x1, t_y1;
   logic [23:0]  t_color;
   logic         t_busy, t_grant, t_cmd_done, t_timeout;
   logic [16:0]  t_pix;

   logic [56:0]  ops;
   logic [81:0]  all_out, t_all;

   int           checks = 0;
   int           errors = 0;
   logic         model_rr = 1'b0;
   exp_t         sb[$];

   logic         stall, stall_en, stub_run;
   int           stub_left;

   always #5 clk = ~clk;

   assign ops     = {eng_x0, eng_y0, eng_x1, eng_y1, eng_fill, eng_color};
   assign all_out = {req_ready, eng_start, eng_abort, ops, busy, grant_id,
                     pix_count, cmd_done, cmd_timeout};
   assign t_all   = {t_ready, t_start, t_abort, t_x0, t_y0, t_x1, t_y1, t_fill,
                     t_color, t_busy, t_grant, t_pix, t_cmd_done, t_timeout};

   draw_cmd_arbiter dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_cmd(req_cmd), .eng_start(eng_start), .eng_x0(eng_x0),
      .eng_y0(eng_y0), .eng_x1(eng_x1), .eng_y1(eng_y1), .eng_fill(eng_fill),
      .eng_color(eng_color), .eng_abort(eng_abort),
      .eng_pixel_valid(eng_pixel_valid), .eng_done(eng_done), .busy(busy),
      .grant_id(grant_id), .pix_count(pix_count), .cmd_done(cmd_done),
      .cmd_timeout(cmd_timeout)
   );

   draw_cmd_arbiter #(.TIMEOUT_CYCLES(16)) dut_to (
      .clk(clk), .rst(rst), .req_valid(t_valid), .req_ready(t_ready),
      .req_cmd(t_cmd), .eng_start(t_start), .eng_x0(t_x0), .eng_y0(t_y0),
      .eng_x1(t_x1), .eng_y1(t_y1), .eng_fill(t_fill), .eng_color(t_color),
      .eng_abort(t_abort), .eng_pixel_valid(t_pv), .eng_done(t_done),
      .busy(t_busy), .grant_id(t_grant), .pix_count(t_pix),
      .cmd_done(t_cmd_done), .cmd_timeout(t_timeout)
   );

   // Engine stub: latches the rectangle size on start, then emits one pixel
   // per non-stalled cycle and raises done together with the last pixel.
   always @(posedge clk) begin
      if (rst || eng_abort) begin
         stub_run  <= 1'b0;
         stub_left <= 0;
         stall     <= 1'b0;
      end else begin
         stall <= stall_en ? ($urandom_range(0, 3) == 0) : 1'b0;
         if (eng_start) begin
            stub_run  <= 1'b1;
            stub_left <= (int'(eng_x1) - int'(eng_x0) + 1) *
                         (int'(eng_y1) - int'(eng_y0) + 1);
         end else if (stub_run && !stall) begin
            stub_left <= stub_left - 1;
            if (stub_left <= 1) stub_run <= 1'b0;
         end
      end
   end

   assign eng_pixel_valid = stub_run && !stall;
   assign eng_done        = eng_pixel_valid && (stub_left <= 1);

   function automatic logic [56:0] mk(input logic [7:0] x0, input logic [7:0] y0,
                                      input logic [7:0] x1, input logic [7:0] y1,
                                      input logic fill, input logic [23:0] color);
      return {x0, y0, x1, y1, fill, color};
   endfunction

   // Reference normalisation and pixel count for one command.
   function automatic exp_t model(input logic g, input logic [56:0] c);
      exp_t       e;
      logic [7:0] ax0, ay0, ax1, ay1, nx0, ny0, nx1, ny1;
      ax0 = c[56:49];
      ay0 = c[48:41];
      ax1 = c[40:33];
      ay1 = c[32:25];
      nx0 = (ax0 < ax1) ? ax0 : ax1;
      nx1 = (ax0 < ax1) ? ax1 : ax0;
      ny0 = (ay0 < ay1) ? ay0 : ay1;
      ny1 = (ay0 < ay1) ? ay1 : ay0;
      e.g     = g;
      e.ops   = {nx0, ny0, nx1, ny1, c[24], c[23:0]};
      e.count = (int'(nx1) - int'(nx0) + 1) * (int'(ny1) - int'(ny0) + 1);
      return e;
   endfunction

   // Presents a command on a lone requester, waits for the handshake and
   // returns just after the accepting edge with valid dropped.
   task automatic issue(input int r, input logic [56:0] c, output bit ok);
      ok = 1'b0;
      @(negedge clk);
      req_cmd[57*r +: 57] = c;
      req_valid[r] = 1'b1;
      for (int i = 0; i < 200; i++) begin
         #1;
         if (req_ready[r]) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (ok) begin
         sb.push_back(model(r[0], c));
         model_rr = ~r[0];
         @(posedge clk);
         #1;
      end
      req_valid[r] = 1'b0;
   endtask

   // Waits (bounded) for cmd_done and returns at the negedge where it is high.
   task automatic wait_done(input int limit, output bit done_ok, output bit to_seen);
      done_ok = 1'b0;
      to_seen = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (cmd_timeout) to_seen = 1'b1;
         if (cmd_done) begin
            done_ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req_valid = 2'b00;
      req_cmd = '0;
      t_valid = 2'b00;
      t_cmd = '0;
      repeat (3) @(negedge clk);
      checks++;
      if (all_out !== 82'd0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got %0h, expected 0", all_out);
      end
      checks++;
      if (t_all !== 82'd0) begin
         errors++;
         $display("[TB] FAIL reset_outputs_to: got %0h, expected 0", t_all);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (all_out !== 82'd0) begin
         errors++;
         $display("[TB] FAIL idle_after_reset: got %0h, expected 0", all_out);
      end
   endtask

   task automatic test_single();
      bit   ok, d, t;
      exp_t e;
      issue(0, mk(8'd10, 8'd10, 8'd11, 8'd11, 1'b1, 24'hFF0000), ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("[TB] FAIL single_accept: got no handshake, expected accept");
         return;
      end
      req_cmd[56:0] = mk(8'd1, 8'd2, 8'd3, 8'd4, 1'b0, 24'h123456);
      e = sb[0];
      @(negedge clk);
      checks++;
      if (eng_start !== 1'b1) begin
         errors++;
         $display("[TB] FAIL start_latency: got %0b, expected 1", eng_start);
      end
      checks++;
      if (ops !== mk(8'd10, 8'd10, 8'd11, 8'd11, 1'b1, 24'hFF0000)) begin
         errors++;
         $display("[TB] FAIL single_operands: got %0h, expected %0h", ops, e.ops);
      end
      checks++;
      if ({busy, grant_id} !== 2'b10) begin
         errors++;
         $display("[TB] FAIL single_busy_grant: got %0b, expected 10", {busy, grant_id});
      end
      @(negedge clk);
      checks++;
      if (eng_start !== 1'b0) begin
         errors++;
         $display("[TB] FAIL start_width: got %0b, expected 0", eng_start);
      end
      wait_done(500, d, t);
      checks++;
      if (!d) begin
         errors++;
         $display("[TB] FAIL single_done: got no cmd_done, expected one");
         return;
      end
      e = sb.pop_front();
      checks++;
      if (ops !== e.ops) begin
         errors++;
         $display("[TB] FAIL operands_held: got %0h, expected %0h", ops, e.ops);
      end
      @(negedge clk);
      checks++;
      if ({cmd_done, busy} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL single_idle: got %0b, expected 00", {cmd_done, busy});
      end
      checks++;
      if (pix_count !== 17'(e.count) || e.count != 4) begin
         errors++;
         $display("[TB] FAIL single_pix: got %0d, expected 4", pix_count);
      end
   endtask

   task automatic test_normalise();
      bit   ok, d, t;
      exp_t e;
      issue(1, mk(8'd20, 8'd5, 8'd15, 8'd3, 1'b0, 24'h00FF00), ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("[TB] FAIL norm_accept: got no handshake, expected accept");
         return;
      end
      @(negedge clk);
      checks++;
      if ({eng_x0, eng_y0, eng_x1, eng_y1} !== {8'd15, 8'd3, 8'd20, 8'd5}) begin
         errors++;
         $display("[TB] FAIL norm_corners: got %0h, expected 0f03_1405",
                  {eng_x0, eng_y0, eng_x1, eng_y1});
      end
      wait_done(1000, d, t);
      checks++;
      if (!d) begin
         errors++;
         $display("[TB] FAIL norm_done: got no cmd_done, expected one");
         return;
      end
      e = sb.pop_front();
      checks++;
      if (grant_id !== 1'b1) begin
         errors++;
         $display("[TB] FAIL norm_grant: got %0b, expected 1", grant_id);
      end
      @(negedge clk);
      checks++;
      if (pix_count !== 17'd18) begin
         errors++;
         $display("[TB] FAIL norm_pix: got %0d, expected 18 (model %0d)", pix_count, e.count);
      end
      // Lone requester again with a degenerate 1-pixel rectangle.
      issue(1, mk(8'd7, 8'd7, 8'd7, 8'd7, 1'b1, 24'h123456), ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("[TB] FAIL lone_regrant: got no handshake, expected accept");
         return;
      end
      wait_done(500, d, t);
      checks++;
      if (!d) begin
         errors++;
         $display("[TB] FAIL degenerate_done: got no cmd_done, expected one");
         return;
      end
      e = sb.pop_front();
      @(negedge clk);
      checks++;
      if (pix_count !== 17'd1) begin
         errors++;
         $display("[TB] FAIL degenerate_pix: got %0d, expected 1 (model %0d)", pix_count, e.count);
      end
   endtask

   task automatic test_back_to_back();
      logic [56:0] cmds0[4], cmds1[4];
      int          idx[2];
      int          done_n;
      bit          acc_pend, pix_pend, both_seen;
      logic        acc_g, g;
      logic [1:0]  exp_ready;
      exp_t        cur;
      for (int i = 0; i < 4; i++) begin
         cmds0[i] = mk(8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
                       8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
                       1'($urandom_range(0, 1)), 24'($urandom));
         cmds1[i] = mk(8'($urandom_range(100, 115)), 8'($urandom_range(50, 65)),
                       8'($urandom_range(100, 115)), 8'($urandom_range(50, 65)),
                       1'($urandom_range(0, 1)), 24'($urandom));
      end
      idx[0] = 0;
      idx[1] = 0;
      done_n = 0;
      acc_pend = 1'b0;
      pix_pend = 1'b0;
      both_seen = 1'b0;
      acc_g = 1'b0;
      cur = '{g: 1'b0, ops: '0, count: 0};
      @(negedge clk);
      req_cmd[56:0] = cmds0[0];
      req_cmd[113:57] = cmds1[0];
      req_valid = 2'b11;
      for (int cyc = 0; cyc < 20000 && done_n < 8; cyc++) begin
         if (acc_pend) begin
            idx[acc_g]++;
            if (idx[acc_g] < 4) begin
               req_cmd[57*acc_g +: 57] = acc_g ? cmds1[idx[1]] : cmds0[idx[0]];
            end else begin
               req_valid[acc_g] = 1'b0;
            end
            acc_pend = 1'b0;
         end
         #1;
         if (req_ready == 2'b11) both_seen = 1'b1;
         if (req_ready != 2'b00) begin
            g = req_valid[model_rr] ? model_rr : ~model_rr;
            exp_ready = g ? 2'b10 : 2'b01;
            checks++;
            if (req_ready !== exp_ready) begin
               errors++;
               $display("[TB] FAIL grant_order: got %0b, expected %0b", req_ready, exp_ready);
            end
            sb.push_back(model(g, g ? cmds1[idx[1]] : cmds0[idx[0]]));
            model_rr = ~g;
            acc_pend = 1'b1;
            acc_g = req_ready[1];
         end
         if (pix_pend) begin
            pix_pend = 1'b0;
            checks++;
            if (pix_count !== 17'(cur.count)) begin
               errors++;
               $display("[TB] FAIL b2b_pix: got %0d, expected %0d", pix_count, cur.count);
            end
         end
         if (cmd_done) begin
            done_n++;
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("[TB] FAIL b2b_spurious_done: got cmd_done, expected none");
            end else begin
               cur = sb.pop_front();
               if ({grant_id, ops} !== {cur.g, cur.ops}) begin
                  errors++;
                  $display("[TB] FAIL b2b_cmd: got %0h, expected %0h",
                           {grant_id, ops}, {cur.g, cur.ops});
               end
               pix_pend = 1'b1;
            end
         end
         @(negedge clk);
      end
      req_valid = 2'b00;
      checks++;
      if (done_n != 8) begin
         errors++;
         $display("[TB] FAIL b2b_count: got %0d completions, expected 8", done_n);
      end
      checks++;
      if (both_seen) begin
         errors++;
         $display("[TB] FAIL both_ready: got 11, expected at most one bit");
      end
      if (pix_pend) begin
         checks++;
         if (pix_count !== 17'(cur.count)) begin
            errors++;
            $display("[TB] FAIL b2b_last_pix: got %0d, expected %0d", pix_count, cur.count);
         end
      end
   endtask

   task automatic test_mid_reset();
      bit          ok, d, t;
      exp_t        e;
      logic [56:0] c0, c1;
      stall_en = 1'b0;
      issue(0, mk(8'd0, 8'd0, 8'd200, 8'd200, 1'b1, 24'hABCDEF), ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("[TB] FAIL mid_accept: got no handshake, expected accept");
         return;
      end
      void'(sb.pop_front());
      repeat (10) @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL busy_in_wait: got %0b, expected 1", busy);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (all_out !== 82'd0) begin
         errors++;
         $display("[TB] FAIL reset_mid_wait: got %0h, expected 0", all_out);
      end
      rst = 1'b0;
      stall_en = 1'b1;
      c0 = mk(8'd5, 8'd6, 8'd3, 8'd4, 1'b0, 24'h0000FF);
      c1 = mk(8'd9, 8'd9, 8'd9, 8'd9, 1'b1, 24'h00FFFF);
      req_cmd = {c1, c0};
      req_valid = 2'b11;
      #1;
      checks++;
      if (req_ready !== 2'b01) begin
         errors++;
         $display("[TB] FAIL rr_after_reset: got %0b, expected 01", req_ready);
      end
      sb.push_back(model(1'b0, c0));
      model_rr = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 2'b00;
      wait_done(500, d, t);
      checks++;
      if (!d) begin
         errors++;
         $display("[TB] FAIL post_reset_done: got no cmd_done, expected one");
         return;
      end
      e = sb.pop_front();
      checks++;
      if ({grant_id, ops} !== {e.g, e.ops}) begin
         errors++;
         $display("[TB] FAIL post_reset_cmd: got %0h, expected %0h", {grant_id, ops}, {e.g, e.ops});
      end
      @(negedge clk);
      checks++;
      if (pix_count !== 17'd9) begin
         errors++;
         $display("[TB] FAIL post_reset_pix: got %0d, expected 9", pix_count);
      end
   endtask

   task automatic test_timeout();
      int abort_k, to_k, idle_k, abort_n;
      t_pv = 1'b1;
      t_done = 1'b0;
      @(negedge clk);
      t_cmd[56:0] = mk(8'd1, 8'd1, 8'd2, 8'd2, 1'b1, 24'h112233);
      t_valid = 2'b01;
      #1;
      checks++;
      if (t_ready !== 2'b01) begin
         errors++;
         $display("[TB] FAIL to_accept: got %0b, expected 01", t_ready);
      end
      @(posedge clk);
      #1;
      t_valid = 2'b00;
      @(negedge clk);
      checks++;
      if (t_start !== 1'b1) begin
         errors++;
         $display("[TB] FAIL to_start: got %0b, expected 1", t_start);
      end
      abort_k = -1;
      to_k = -1;
      idle_k = -1;
      abort_n = 0;
      for (int k = 1; k <= 25; k++) begin
         @(negedge clk);
         if (t_abort) abort_n++;
         if (t_abort && abort_k < 0) abort_k = k;
         if (t_timeout && to_k < 0) to_k = k;
         if (!t_busy && idle_k < 0) idle_k = k;
      end
      checks++;
      if (abort_k != 17 || to_k != 17 || abort_n != 1) begin
         errors++;
         $display("[TB] FAIL abort_timing: got abort@%0d timeout@%0d width %0d, expected 17 17 1",
                  abort_k, to_k, abort_n);
      end
      checks++;
      if (idle_k != 18) begin
         errors++;
         $display("[TB] FAIL busy_drop: got %0d, expected 18", idle_k);
      end
      checks++;
      if (t_pix !== 17'd16) begin
         errors++;
         $display("[TB] FAIL to_pix: got %0d, expected 16", t_pix);
      end
      t_cmd[113:57] = mk(8'd4, 8'd4, 8'd5, 8'd5, 1'b0, 24'h445566);
      t_valid = 2'b10;
      #1;
      checks++;
      if (t_ready !== 2'b10) begin
         errors++;
         $display("[TB] FAIL to_next_accept: got %0b, expected 10", t_ready);
      end
      @(posedge clk);
      #1;
      t_valid = 2'b00;
      @(negedge clk);
      checks++;
      if ({t_start, t_grant} !== 2'b11) begin
         errors++;
         $display("[TB] FAIL to_next_start: got %0b, expected 11", {t_start, t_grant});
      end
   endtask

   task automatic test_full_screen();
      bit   ok, d, t;
      exp_t e;
      stall_en = 1'b0;
      issue(1, mk(8'd0, 8'd0, 8'd255, 8'd255, 1'b1, 24'hFFFFFF), ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("[TB] FAIL full_accept: got no handshake, expected accept");
         return;
      end
      wait_done(80000, d, t);
      checks++;
      if (!d || t) begin
         errors++;
         $display("[TB] FAIL full_done: got done=%0b timeout=%0b, expected done=1 timeout=0", d, t);
         return;
      end
      e = sb.pop_front();
      @(negedge clk);
      checks++;
      if (pix_count !== 17'd65536) begin
         errors++;
         $display("[TB] FAIL full_pix: got %0d, expected 65536 (model %0d)", pix_count, e.count);
      end
   endtask

   initial begin
      rst = 1'b1;
      stall_en = 1'b1;
      t_pv = 1'b0;
      t_done = 1'b0;
      test_reset();
      test_single();
      test_normalise();
      test_back_to_back();
      test_mid_reset();
      test_timeout();
      test_full_screen();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/draw_cmd_arbiter.md
Name: draw_cmd_arbiter

Overview:
Two-requester command scheduler for the rectangle rasteriser engine (start/done, x0..y1, fill_enable, color, pixel_valid interface).
- Accepts draw commands over valid/ready handshakes and arbitrates round-robin between the requesters.
- Normalises coordinates so x0<=x1 and y0<=y1, then issues a one-cycle start to the engine and holds the operands stable until done.
- Counts emitted pixels per command and aborts a hung engine with a watchdog.
- Sits between the command front-ends (host port and display-list reader) and the single shared engine.

Parameters:
TIMEOUT_CYCLES, 70000, WAIT-state cycles before abort (must exceed 65536+overhead); counter is 17 bits.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req_valid  in  2  per-requester command valid
req_ready  out  2  per-requester accept (combinational)
req_cmd  in  114  two packed 57-bit commands; req i at [57i+56:57i]; fields MSB→LSB: x0[8], y0[8], x1[8], y1[8], fill[1], color[24]
eng_start  out  1  one-cycle start pulse to engine
eng_x0, eng_y0, eng_x1, eng_y1  out  8 each  normalised rectangle corners
eng_fill  out  1  fill_enable to engine
eng_color  out  24  colour to engine
eng_abort  out  1  one-cycle pulse, OR'd into engine reset
eng_pixel_valid  in  1  engine pixel strobe
eng_done  in  1  engine completion pulse
busy  out  1  high in every state except IDLE
grant_id  out  1  requester owning the current/last command
pix_count  out  17  pixel count of the last completed command
cmd_done  out  1  one-cycle completion pulse
cmd_timeout  out  1  one-cycle abort pulse

Behaviour:
- Reset values: req_ready=0, eng_start=0, eng_abort=0, all eng_* operands 0, busy=0, grant_id=0, pix_count=0, cmd_done=0, cmd_timeout=0, rr pointer=0, state=IDLE. Reset mid-command returns to IDLE immediately. The engine must be reset by the same rst.
- States: IDLE, ISSUE, WAIT, COMPLETE, ABORT.
- IDLE:
  - Grant g = rr if req_valid[rr]; otherwise the other requester if its valid is set.
  - req_ready[g]=1 only in IDLE and only for g with req_valid[g]=1; at most one ready bit is set.
  - On acceptance:
    - eng_x0=min(x0,x1), eng_x1=max(x0,x1); same rule for y.
    - Latch fill/color, grant_id<=g, rr<=~g, clear the running pixel counter and timer.
    - Go to ISSUE.
- ISSUE (1 cycle): eng_start=1, then go to WAIT. Accept-to-start latency is exactly 1 cycle.
- WAIT:
  - Operands are held constant.
  - Running counter increments on each eng_pixel_valid.
  - Timer increments every cycle.
  - On eng_done: go to COMPLETE. A pixel_valid in the same cycle is still counted.
  - Else if timer==TIMEOUT_CYCLES-1: go to ABORT.
- COMPLETE (1 cycle): cmd_done=1, pix_count<=running counter, go to IDLE.
- ABORT (1 cycle): eng_abort=1, cmd_timeout=1, pix_count<=running counter, go to IDLE.
- eng_done and eng_pixel_valid are ignored outside WAIT.
- Both requesters valid in IDLE: rr decides, so back-to-back commands strictly alternate. A lone requester is served every time.
- Minimum command spacing: 3 cycles plus engine run time.
- req_cmd is sampled only in the acceptance cycle; later changes have no effect.
- Degenerate rectangle (x0==x1, y0==y1) is a legal 1-pixel command.

Test Plan:
- Req0 only, cmd (10,10)-(11,11), fill=1, color=0xFF0000 → eng_start exactly 1 cycle after accept; operands 10,10,11,11; cmd_done; pix_count=4; grant_id=0.
- Req1 cmd (20,5)-(15,3) → normalised eng_x0=15, eng_x1=20, eng_y0=3, eng_y1=5; pix_count=18.
- Both valid continuously, 4 commands each → grant order 0,1,0,1,…; req_ready never has both bits set; each cmd_done matches its own count.
- Engine stub that never asserts done, TIMEOUT_CYCLES=16 → eng_abort and cmd_timeout pulse 16 cycles after entering WAIT; busy drops the next cycle; the next request is accepted.
- rst asserted mid-WAIT → next cycle all outputs are at reset values, state is IDLE, rr=0; a new command runs normally.
- Full-screen cmd (0,0)-(255,255) with default timeout → pix_count=65536, no timeout.
